// File: rtl/tap_window_gen.sv
// ---------------------------------------------------------------------------
// tap_window_gen
//
// Turns a stream of 8-bit source pixels into a stream of 4-tap windows for the
// bicubic weight tables. Each row of ROW_LEN pixels yields exactly ROW_LEN
// windows {p[k-1], p[k], p[k+1], p[k+2]}. Indices are clamped to the row, so
// the edge pixels are replicated. Taps are presented in 8.7 fixed point as
// {pixel, 7'b0}.
//
// Parameters
//   ROW_LEN   pixels per source row (>= 3)
//   CNT_W     width of the column counter (must hold ROW_LEN)
//
// Ports
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-high reset
//   pix_in     source pixel, unsigned
//   pix_valid  pix_in valid
//   pix_ready  pixel accepted this cycle when pix_valid is also high
//   in_0..in_3 taps p[k-1], p[k], p[k+1], p[k+2] as {pixel, 7'b0}
//   tap_valid  taps hold a valid window
//   tap_ready  downstream consumes the window when tap_valid is also high
//   tap_last   current window is the last of its row
// ---------------------------------------------------------------------------
module tap_window_gen #(
  parameter int ROW_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [14:0] in_0,
  output logic [14:0] in_1,
  output logic [14:0] in_2,
  output logic [14:0] in_3,
  output logic        tap_valid,
  input  logic        tap_ready,
  output logic        tap_last
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(ROW_LEN - 1);
  localparam logic [CNT_W-1:0] COL_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [1:0]       fill_cnt_r, fill_cnt_s;
  logic [CNT_W-1:0] col_cnt_r, col_cnt_s;
  logic             flush_idx_r, flush_idx_s;

  // History of the last three accepted pixels: hist0 is the newest.
  // The window being produced is always {hist2, hist1, hist0, new_pix}.
  logic [7:0]       hist0_r, hist1_r, hist2_r;
  logic [7:0]       hist0_s, hist1_s, hist2_s;
  logic [7:0]       new_pix_s;

  logic             slot_free_s;
  logic             pix_ready_s;
  logic             load_s;
  logic             load_last_s;

  logic [14:0]      in_0_r, in_1_r, in_2_r, in_3_r;
  logic             tap_valid_r, tap_last_r;

  assign slot_free_s = !tap_valid_r || tap_ready;

  // Gate with rst so that nothing looks acceptable while reset is applied.
  assign pix_ready = pix_ready_s && !rst;

  assign in_0      = in_0_r;
  assign in_1      = in_1_r;
  assign in_2      = in_2_r;
  assign in_3      = in_3_r;
  assign tap_valid = tap_valid_r;
  assign tap_last  = tap_last_r;

  // Next-state, pixel acceptance and window-load decisions.
  always_comb begin
    state_s     = state_r;
    fill_cnt_s  = fill_cnt_r;
    col_cnt_s   = col_cnt_r;
    flush_idx_s = flush_idx_r;
    hist0_s     = hist0_r;
    hist1_s     = hist1_r;
    hist2_s     = hist2_r;
    new_pix_s   = hist0_r;
    pix_ready_s = 1'b0;
    load_s      = 1'b0;
    load_last_s = 1'b0;

    case (state_r)
      ST_FILL: begin
        // p[0] and p[1] never touch the output register, so they may be
        // taken even while the previous row's last window is still waiting.
        if (fill_cnt_r == 2'd2) begin
          pix_ready_s = slot_free_s;
        end else begin
          pix_ready_s = 1'b1;
        end

        if (pix_valid && pix_ready_s) begin
          col_cnt_s = col_cnt_r + COL_ONE;
          if (fill_cnt_r == 2'd0) begin
            // p[0] stands in for the clamped p[-1] as well.
            hist2_s    = pix_in;
            hist1_s    = pix_in;
            hist0_s    = pix_in;
            fill_cnt_s = 2'd1;
          end else if (fill_cnt_r == 2'd1) begin
            hist2_s    = hist1_r;
            hist1_s    = hist0_r;
            hist0_s    = pix_in;
            fill_cnt_s = 2'd2;
          end else begin
            hist2_s     = hist1_r;
            hist1_s     = hist0_r;
            hist0_s     = pix_in;
            new_pix_s   = pix_in;
            load_s      = 1'b1;
            fill_cnt_s  = 2'd0;
            flush_idx_s = 1'b0;
            // A 3-pixel row has just received its final pixel.
            if (ROW_LEN == 3) begin
              state_s = ST_FLUSH;
            end else begin
              state_s = ST_RUN;
            end
          end
        end else begin
          fill_cnt_s = fill_cnt_r;
        end
      end

      ST_RUN: begin
        pix_ready_s = slot_free_s;
        if (pix_valid && pix_ready_s) begin
          hist2_s   = hist1_r;
          hist1_s   = hist0_r;
          hist0_s   = pix_in;
          new_pix_s = pix_in;
          load_s    = 1'b1;
          col_cnt_s = col_cnt_r + COL_ONE;
          if (col_cnt_r == COL_LAST) begin
            state_s     = ST_FLUSH;
            flush_idx_s = 1'b0;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end

      ST_FLUSH: begin
        // The right edge is replicated by feeding hist0 back in as p[k+2].
        pix_ready_s = 1'b0;
        if (slot_free_s) begin
          hist2_s   = hist1_r;
          hist1_s   = hist0_r;
          hist0_s   = hist0_r;
          new_pix_s = hist0_r;
          load_s    = 1'b1;
          if (flush_idx_r == 1'b0) begin
            flush_idx_s = 1'b1;
          end else begin
            // Last window is now in the output register; FILL only takes
            // p[0]/p[1] until that window has been consumed.
            load_last_s = 1'b1;
            flush_idx_s = 1'b0;
            col_cnt_s   = {CNT_W{1'b0}};
            state_s     = ST_FILL;
          end
        end else begin
          state_s = ST_FLUSH;
        end
      end

      default: begin
        state_s     = ST_FILL;
        fill_cnt_s  = 2'd0;
        col_cnt_s   = {CNT_W{1'b0}};
        flush_idx_s = 1'b0;
      end
    endcase
  end

  // Control state and pixel history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_FILL;
      fill_cnt_r  <= 2'd0;
      col_cnt_r   <= {CNT_W{1'b0}};
      flush_idx_r <= 1'b0;
      hist0_r     <= 8'd0;
      hist1_r     <= 8'd0;
      hist2_r     <= 8'd0;
    end else begin
      state_r     <= state_s;
      fill_cnt_r  <= fill_cnt_s;
      col_cnt_r   <= col_cnt_s;
      flush_idx_r <= flush_idx_s;
      hist0_r     <= hist0_s;
      hist1_r     <= hist1_s;
      hist2_r     <= hist2_s;
    end
  end

  // Output window register: load, drain on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_0_r      <= 15'd0;
      in_1_r      <= 15'd0;
      in_2_r      <= 15'd0;
      in_3_r      <= 15'd0;
      tap_valid_r <= 1'b0;
      tap_last_r  <= 1'b0;
    end else if (load_s) begin
      in_0_r      <= {hist2_r, 7'b0000000};
      in_1_r      <= {hist1_r, 7'b0000000};
      in_2_r      <= {hist0_r, 7'b0000000};
      in_3_r      <= {new_pix_s, 7'b0000000};
      tap_valid_r <= 1'b1;
      tap_last_r  <= load_last_s;
    end else if (tap_ready) begin
      tap_valid_r <= 1'b0;
      tap_last_r  <= 1'b0;
    end else begin
      tap_valid_r <= tap_valid_r;
      tap_last_r  <= tap_last_r;
    end
  end

endmodule
